// File: rtl/mem_wb_writeback_pkg.sv
// Shared constants and encodings for the MEM/WB writeback stage of the pipelined MIPS core.
package mem_wb_writeback_pkg;

  localparam int CORE_DW       = 32;
  localparam int CORE_RW       = 5;
  localparam int CORE_LINK_REG = 31;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10
  } load_size_e;

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Little-endian load alignment: picks the addressed byte/half/word out of a memory
// word and sign- or zero-extends it to the datapath width.
module mem_wb_writeback_load_align
  import mem_wb_writeback_pkg::*;
#(
  parameter int DW = CORE_DW
) (
  input  logic [DW-1:0] i_mem_rdata,
  input  logic [1:0]    i_off,
  input  logic [1:0]    i_size,
  input  logic          i_unsigned,
  output logic [DW-1:0] o_data
);

  function automatic logic [DW-1:0] ext_byte(input logic [7:0] b, input logic u);
    return {{(DW-8){b[7] & ~u}}, b};
  endfunction

  function automatic logic [DW-1:0] ext_half(input logic [15:0] h, input logic u);
    return {{(DW-16){h[15] & ~u}}, h};
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension; off[0] is ignored for halves (no misalignment trap)
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = i_mem_rdata;
    case (i_off)
      2'b00:   w_byte = i_mem_rdata[7:0];
      2'b01:   w_byte = i_mem_rdata[15:8];
      2'b10:   w_byte = i_mem_rdata[23:16];
      2'b11:   w_byte = i_mem_rdata[31:24];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    if (i_off[1]) begin
      w_half = i_mem_rdata[31:16];
    end else begin
      w_half = i_mem_rdata[15:0];
    end
    case (i_size)
      LS_BYTE: o_data = ext_byte(w_byte, i_unsigned);
      LS_HALF: o_data = ext_half(w_half, i_unsigned);
      LS_WORD: o_data = i_mem_rdata;
      default: o_data = i_mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: selects and gates the register-file write, bypasses it
// onto the decode read ports, and counts retired instructions.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int DW       = CORE_DW,
  parameter int RW       = CORE_RW,
  parameter int LINK_REG = CORE_LINK_REG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_alu_result,
  input  logic [DW-1:0] in_mem_rdata,
  input  logic [DW-1:0] in_pc_plus4,
  input  logic [RW-1:0] in_dest_reg,
  input  logic          in_reg_write,
  input  logic          in_mem_to_reg,
  input  logic          in_link,
  input  logic [1:0]    in_load_size,
  input  logic          in_load_unsigned,
  input  logic          stall,
  input  logic          flush,
  input  logic [RW-1:0] rf_raddr0,
  input  logic [RW-1:0] rf_raddr1,
  input  logic [DW-1:0] rf_rdata0,
  input  logic [DW-1:0] rf_rdata1,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_write_register,
  output logic [DW-1:0] wb_write_data,
  output logic [DW-1:0] id_rdata0,
  output logic [DW-1:0] id_rdata1,
  output logic [31:0]   retire_count
);

  logic          r_valid;
  logic [DW-1:0] r_alu_result;
  logic [DW-1:0] r_mem_rdata;
  logic [DW-1:0] r_pc_plus4;
  logic [RW-1:0] r_dest_reg;
  logic          r_reg_write;
  logic          r_mem_to_reg;
  logic          r_link;
  logic [1:0]    r_load_size;
  logic          r_load_unsigned;
  logic [31:0]   r_retire_count;

  logic [DW-1:0] w_load_data;
  logic [RW-1:0] w_write_register;
  logic          w_reg_write;

  // Stage register: rst > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid         <= 1'b0;
      r_alu_result    <= {DW{1'b0}};
      r_mem_rdata     <= {DW{1'b0}};
      r_pc_plus4      <= {DW{1'b0}};
      r_dest_reg      <= {RW{1'b0}};
      r_reg_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_link          <= 1'b0;
      r_load_size     <= 2'b00;
      r_load_unsigned <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid         <= in_valid;
      r_alu_result    <= in_alu_result;
      r_mem_rdata     <= in_mem_rdata;
      r_pc_plus4      <= in_pc_plus4;
      r_dest_reg      <= in_dest_reg;
      r_reg_write     <= in_reg_write;
      r_mem_to_reg    <= in_mem_to_reg;
      r_link          <= in_link;
      r_load_size     <= in_load_size;
      r_load_unsigned <= in_load_unsigned;
    end
  end

  // The resident instruction retires when it leaves, even if the incoming one is flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_count <= 32'h0000_0000;
    end else if (r_valid && !stall) begin
      r_retire_count <= r_retire_count + 32'h0000_0001;
    end
  end

  mem_wb_writeback_load_align #(
    .DW (DW)
  ) u_load_align (
    .i_mem_rdata (r_mem_rdata),
    .i_off       (r_alu_result[1:0]),
    .i_size      (r_load_size),
    .i_unsigned  (r_load_unsigned),
    .o_data      (w_load_data)
  );

  assign w_write_register = r_link ? RW'(LINK_REG) : r_dest_reg;
  assign w_reg_write      = r_valid & r_reg_write & (w_write_register != {RW{1'b0}});

  // Writeback value selection and write-before-read bypass
  always_comb begin
    wb_write_data = r_alu_result;
    id_rdata0     = rf_rdata0;
    id_rdata1     = rf_rdata1;
    if (r_link) begin
      wb_write_data = r_pc_plus4;
    end else if (r_mem_to_reg) begin
      wb_write_data = w_load_data;
    end else begin
      wb_write_data = r_alu_result;
    end
    if (w_reg_write && (rf_raddr0 == w_write_register)) begin
      id_rdata0 = wb_write_data;
    end else begin
      id_rdata0 = rf_rdata0;
    end
    if (w_reg_write && (rf_raddr1 == w_write_register)) begin
      id_rdata1 = wb_write_data;
    end else begin
      id_rdata1 = rf_rdata1;
    end
  end

  assign wb_reg_write      = w_reg_write;
  assign wb_write_register = w_write_register;
  assign retire_count      = r_retire_count;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed-vector bench for mem_wb_writeback with hand-computed expectations.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_pc_plus4;
  logic [4:0]  in_dest_reg;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic        in_link;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic        stall;
  logic        flush;
  logic [4:0]  rf_raddr0;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata0;
  logic [31:0] rf_rdata1;
  logic        wb_reg_write;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_write_data;
  logic [31:0] id_rdata0;
  logic [31:0] id_rdata1;
  logic [31:0] retire_count;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_writeback dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_alu_result     (in_alu_result),
    .in_mem_rdata      (in_mem_rdata),
    .in_pc_plus4       (in_pc_plus4),
    .in_dest_reg       (in_dest_reg),
    .in_reg_write      (in_reg_write),
    .in_mem_to_reg     (in_mem_to_reg),
    .in_link           (in_link),
    .in_load_size      (in_load_size),
    .in_load_unsigned  (in_load_unsigned),
    .stall             (stall),
    .flush             (flush),
    .rf_raddr0         (rf_raddr0),
    .rf_raddr1         (rf_raddr1),
    .rf_rdata0         (rf_rdata0),
    .rf_rdata1         (rf_rdata1),
    .wb_reg_write      (wb_reg_write),
    .wb_write_register (wb_write_register),
    .wb_write_data     (wb_write_data),
    .id_rdata0         (id_rdata0),
    .id_rdata1         (id_rdata1),
    .retire_count      (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [4:0] dest, input logic rw,
                         input logic m2r, input logic lnk, input logic [1:0] sz,
                         input logic uns);
    in_valid         = v;
    in_alu_result    = alu;
    in_mem_rdata     = mem;
    in_pc_plus4      = pc;
    in_dest_reg      = dest;
    in_reg_write     = rw;
    in_mem_to_reg    = m2r;
    in_link          = lnk;
    in_load_size     = sz;
    in_load_unsigned = uns;
  endtask

  localparam logic [31:0] MEMW = 32'h80FF_7F01;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rf_raddr0 = 5'd0; rf_raddr1 = 5'd0; rf_rdata0 = 32'h0; rf_rdata1 = 32'h0;
    present(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    present(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
    step();
    check_eq("rst_wrw", {31'd0, wb_reg_write}, 32'h0);
    check_eq("rst_wdata", wb_write_data, 32'h0);
    check_eq("rst_count", retire_count, 32'h0);

    rst = 1'b0;
    present(1'b1, 32'h0000_0006, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    rf_raddr0 = 5'd5; rf_rdata0 = 32'd200;
    rf_raddr1 = 5'd1; rf_rdata1 = 32'd100;
    #1;
    check_eq("alu_wrw", {31'd0, wb_reg_write}, 32'h1);
    check_eq("alu_wreg", {27'd0, wb_write_register}, 32'd5);
    check_eq("alu_wdata", wb_write_data, 32'd6);
    check_eq("byp0_hit", id_rdata0, 32'd6);
    check_eq("byp1_miss", id_rdata1, 32'd100);
    check_eq("alu_count", retire_count, 32'd0);

    present(1'b1, 32'h3, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    check_eq("lb_off3", wb_write_data, 32'hFFFF_FF80);
    check_eq("count_1", retire_count, 32'd1);
    present(1'b1, 32'h3, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step();
    check_eq("lbu_off3", wb_write_data, 32'h0000_0080);
    present(1'b1, 32'h2, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    step();
    check_eq("lh_off2", wb_write_data, 32'hFFFF_80FF);
    present(1'b1, 32'h0, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    step();
    check_eq("lhu_off0", wb_write_data, 32'h0000_7F01);
    present(1'b1, 32'h0, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("lw", wb_write_data, MEMW);
    present(1'b1, 32'h1, MEMW, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    check_eq("lb_off1", wb_write_data, 32'h0000_007F);

    present(1'b1, 32'h99, 32'h0, 32'h0000_0040, 5'd0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0);
    step();
    rf_raddr1 = 5'd31; rf_rdata1 = 32'h5555_5555;
    #1;
    check_eq("link_wreg", {27'd0, wb_write_register}, 32'd31);
    check_eq("link_wdata", wb_write_data, 32'h40);
    check_eq("link_wrw", {31'd0, wb_reg_write}, 32'h1);
    check_eq("link_byp1", id_rdata1, 32'h40);

    present(1'b1, 32'h1234, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    rf_raddr0 = 5'd0; rf_rdata0 = 32'h0000_ABCD;
    #1;
    check_eq("r0_wrw", {31'd0, wb_reg_write}, 32'h0);
    check_eq("r0_nobyp", id_rdata0, 32'h0000_ABCD);
    check_eq("count_8", retire_count, 32'd8);

    present(1'b1, 32'h55, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("pre_stall_count", retire_count, 32'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 32'hAA + 32'(i), 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
      step();
      check_eq("stall_wdata", wb_write_data, 32'h55);
      check_eq("stall_wreg", {27'd0, wb_write_register}, 32'd7);
      check_eq("stall_wrw", {31'd0, wb_reg_write}, 32'h1);
      check_eq("stall_count", retire_count, 32'd9);
    end
    stall = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("release_count", retire_count, 32'd10);
    check_eq("bubble_wrw", {31'd0, wb_reg_write}, 32'h0);

    present(1'b1, 32'h11, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    flush = 1'b1;
    present(1'b1, 32'h77, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("flush_wrw", {31'd0, wb_reg_write}, 32'h0);
    check_eq("flush_resident_count", retire_count, 32'd11);
    flush = 1'b0;
    present(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("flush_killed_count", retire_count, 32'd11);

    dut.r_retire_count = 32'hFFFF_FFFF;
    present(1'b1, 32'h22, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("wrap_pre", retire_count, 32'hFFFF_FFFF);
    present(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    check_eq("wrap_zero", retire_count, 32'h0);

    present(1'b1, 32'h33, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    step();
    stall = 1'b1;
    rst = 1'b1;
    step();
    check_eq("rst_stall_wrw", {31'd0, wb_reg_write}, 32'h0);
    check_eq("rst_stall_wdata", wb_write_data, 32'h0);
    check_eq("rst_stall_wreg", {27'd0, wb_write_register}, 32'h0);
    check_eq("rst_stall_count", retire_count, 32'h0);
    rst = 1'b0;
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
